button_repeater: RTL and testbench



---
 rtl/input_pkg.sv | 23 ++
 rtl/button_repeater.sv | 125 ++++++++++++
 tb/tb_button_repeater.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/input_pkg.sv
// ---------------------------------------------------------------------------
// input_pkg
// Shared definitions for the input-path blocks. The state encoding and the
// default timing constants are used by the button auto-repeat generator and
// by other consumers of the debounced button path.
// Ports: none (package).
// ---------------------------------------------------------------------------
package input_pkg;

  // Auto-repeat FSM states. The encoding is fixed so that other blocks
  // can compare against it.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } btn_state_e;

  // Default timing constants.
  localparam int DEF_DELAY_CYCLES = 5_000_000;
  localparam int DEF_RATE_CYCLES  = 1_250_000;
  localparam int DEF_CNT_W        = 24;

endpackage : input_pkg

// File: rtl/button_repeater.sv
// ---------------------------------------------------------------------------
// button_repeater
// Typematic auto-repeat generator for one debounced button. A press pulse
// produces an immediate fire pulse. If the button is still held after
// DELAY_CYCLES, and auto-repeat is enabled, further fire pulses follow every
// RATE_CYCLES until release. With i_repeat_en low, each press fires once.
//
// Ports:
//   i_clk        : system clock, all logic on posedge
//   i_rst        : synchronous active-high reset
//   i_press      : one-cycle pulse, button became pressed
//   i_release    : one-cycle pulse, button became released
//   i_repeat_en  : level, 1 = auto-repeat allowed
//   o_fire       : registered one-cycle action pulse
//   o_held       : registered level, high while state != IDLE
//   o_state      : current FSM state (observation only)
//
// Input pulses carry no handshake: a pulse is consumed on the clock edge
// where it is high. Outputs are registered, so there is no combinational
// path from any input to any output.
// ---------------------------------------------------------------------------
module button_repeater
  import input_pkg::*;
#(
  parameter int DELAY_CYCLES = DEF_DELAY_CYCLES,
  parameter int RATE_CYCLES  = DEF_RATE_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_press,
  input  logic       i_release,
  input  logic       i_repeat_en,
  output logic       o_fire,
  output logic       o_held,
  output btn_state_e o_state
);

  localparam logic [CNT_W-1:0] DelayLoad = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RateLoad  = CNT_W'(RATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntZero   = '0;

  btn_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fire;
  logic             r_held;

  btn_state_e       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_fire_nxt;
  logic             w_cnt_zero;

  assign w_cnt_zero = (r_cnt == CntZero);

  // Next-state, counter and fire decision. Release always has priority,
  // including over a simultaneous press and over a pending cnt==0 decision.
  // The counter is reloaded at zero and never decremented past it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fire_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_press && !i_release) begin
          w_state_nxt = DELAY;
          w_cnt_nxt   = DelayLoad;
          w_fire_nxt  = 1'b1;
        end
      end
      DELAY: begin
        if (i_release) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = CntZero;
        end else if (w_cnt_zero) begin
          // Without repeat enable the counter parks at zero, so raising the
          // enable later fires on the very next decision.
          if (i_repeat_en) begin
            w_state_nxt = REPEAT;
            w_cnt_nxt   = RateLoad;
            w_fire_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CntOne;
        end
      end
      REPEAT: begin
        if (i_release) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = CntZero;
        end else if (w_cnt_zero) begin
          // Keep running the rate timer even when repeat is disabled, so the
          // cadence resumes cleanly if it is re-enabled.
          w_cnt_nxt  = RateLoad;
          w_fire_nxt = i_repeat_en;
        end else begin
          w_cnt_nxt = r_cnt - CntOne;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = CntZero;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= CntZero;
      r_fire  <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_fire  <= w_fire_nxt;
      r_held  <= (w_state_nxt != IDLE);
    end
  end

  assign o_fire  = r_fire;
  assign o_held  = r_held;
  assign o_state = r_state;

endmodule : button_repeater

// File: tb/tb_button_repeater.sv
// ---------------------------------------------------------------------------
// tb_button_repeater
// Scenario bench for button_repeater with DELAY_CYCLES = 8, RATE_CYCLES = 4.
// Cycle numbering: after each reset, cycle 0 is the first cycle with reset
// low. Inputs driven during cycle c are sampled at the edge that starts
// cycle c+1; the expected {held, fire} for cycle c+1 is pushed when the
// stimulus for cycle c is driven and popped right after that edge.
// ---------------------------------------------------------------------------
module tb_button_repeater;
  import input_pkg::*;

  localparam int DLY  = 8;
  localparam int RATE = 4;

  logic       clk;
  logic       i_rst;
  logic       i_press;
  logic       i_release;
  logic       i_repeat_en;
  logic       o_fire;
  logic       o_held;
  btn_state_e o_state;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  button_repeater #(
    .DELAY_CYCLES(DLY),
    .RATE_CYCLES (RATE),
    .CNT_W       (8)
  ) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_press    (i_press),
    .i_release  (i_release),
    .i_repeat_en(i_repeat_en),
    .o_fire     (o_fire),
    .o_held     (o_held),
    .o_state    (o_state)
  );

  // ---- clock / reset ------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout got still-running exp finished");
    $fatal(1, "timeout");
  end

  // Leaves the bench 1 time unit into cycle 0 with reset released.
  task automatic do_reset();
    i_rst     = 1'b1;
    i_press   = 1'b0;
    i_release = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
  endtask

  // ---- scenarios ----------------------------------------------------------
  task automatic test_reset();
    logic [1:0] got;
    i_repeat_en = 1'b1;
    i_rst = 1'b0;
    i_press = 1'b1;
    i_release = 1'b0;
    @(posedge clk); #1;
    i_press = 1'b0;
    do_reset();
    exp_q.push_back(2'b00);
    got = exp_q.pop_front();
    checks++;
    if ({o_held, o_fire} !== got) begin
      errors++;
      $display("FAIL reset_outputs got %b exp %b", {o_held, o_fire}, got);
    end
    checks++;
    if (o_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d exp %0d", o_state, IDLE);
    end
  endtask

  // Press at 10, release at 40.
  task automatic test_repeat();
    logic [1:0] got;
    int n;
    i_repeat_en = 1'b1;
    do_reset();
    for (int c = 0; c < 45; c++) begin
      n = c + 1;
      i_press   = (c == 10);
      i_release = (c == 40);
      exp_q.push_back({(n >= 11 && n <= 40),
                       (n == 11 || (n >= 19 && n <= 39 && (n - 19) % RATE == 0))});
      @(posedge clk); #1;
      got = exp_q.pop_front();
      checks++;
      if ({o_held, o_fire} !== got) begin
        errors++;
        $display("FAIL repeat cyc %0d got held/fire %b exp %b", n, {o_held, o_fire}, got);
      end
    end
  endtask

  // Press at 10, release at 15 before the first repeat.
  task automatic test_early_release();
    logic [1:0] got;
    int n;
    i_repeat_en = 1'b1;
    do_reset();
    for (int c = 0; c < 25; c++) begin
      n = c + 1;
      i_press   = (c == 10);
      i_release = (c == 15);
      exp_q.push_back({(n >= 11 && n <= 15), (n == 11)});
      @(posedge clk); #1;
      got = exp_q.pop_front();
      checks++;
      if ({o_held, o_fire} !== got) begin
        errors++;
        $display("FAIL early_release cyc %0d got held/fire %b exp %b", n, {o_held, o_fire}, got);
      end
    end
  endtask

  // repeat_en low, press at 10, enable raised at 30, release at 60.
  task automatic test_no_repeat();
    logic [1:0] got;
    int n;
    do_reset();
    for (int c = 0; c < 65; c++) begin
      n = c + 1;
      i_press     = (c == 10);
      i_release   = (c == 60);
      i_repeat_en = (c >= 30);
      exp_q.push_back({(n >= 11 && n <= 60),
                       (n == 11 || (n >= 31 && n <= 60 && (n - 31) % RATE == 0))});
      @(posedge clk); #1;
      got = exp_q.pop_front();
      checks++;
      if ({o_held, o_fire} !== got) begin
        errors++;
        $display("FAIL no_repeat cyc %0d got held/fire %b exp %b", n, {o_held, o_fire}, got);
      end
    end
    i_repeat_en = 1'b1;
  endtask

  // press+release together at 5, press at 10, extra press at 14, release at 30.
  task automatic test_collision();
    logic [1:0] got;
    int n;
    i_repeat_en = 1'b1;
    do_reset();
    for (int c = 0; c < 35; c++) begin
      n = c + 1;
      i_press   = (c == 5 || c == 10 || c == 14);
      i_release = (c == 5 || c == 30);
      exp_q.push_back({(n >= 11 && n <= 30),
                       (n == 11 || (n >= 19 && n <= 30 && (n - 19) % RATE == 0))});
      @(posedge clk); #1;
      got = exp_q.pop_front();
      checks++;
      if ({o_held, o_fire} !== got) begin
        errors++;
        $display("FAIL collision cyc %0d got held/fire %b exp %b", n, {o_held, o_fire}, got);
      end
    end
  endtask

  // Press at 10, reset at 20 (in REPEAT), new press at 25, release at 28.
  task automatic test_reset_mid();
    logic [1:0] got;
    int n;
    i_repeat_en = 1'b1;
    do_reset();
    for (int c = 0; c < 35; c++) begin
      n = c + 1;
      i_press   = (c == 10 || c == 25);
      i_release = (c == 28);
      i_rst     = (c == 20);
      exp_q.push_back({((n >= 11 && n <= 20) || (n >= 26 && n <= 28)),
                       (n == 11 || n == 19 || n == 26)});
      @(posedge clk); #1;
      got = exp_q.pop_front();
      checks++;
      if ({o_held, o_fire} !== got) begin
        errors++;
        $display("FAIL reset_mid cyc %0d got held/fire %b exp %b", n, {o_held, o_fire}, got);
      end
    end
    i_rst = 1'b0;
  endtask

  // Release at 18, the cycle where the delay counter sits at zero.
  task automatic test_release_at_zero();
    logic [1:0] got;
    int n;
    i_repeat_en = 1'b1;
    do_reset();
    for (int c = 0; c < 25; c++) begin
      n = c + 1;
      i_press   = (c == 10);
      i_release = (c == 18);
      exp_q.push_back({(n >= 11 && n <= 18), (n == 11)});
      @(posedge clk); #1;
      got = exp_q.pop_front();
      checks++;
      if ({o_held, o_fire} !== got) begin
        errors++;
        $display("FAIL release_at_zero cyc %0d got held/fire %b exp %b", n, {o_held, o_fire}, got);
      end
    end
  endtask

  // Random hold lengths, each hold followed immediately by the next press.
  task automatic test_back_to_back();
    logic [1:0] got;
    int n, p, r, len;
    i_repeat_en = 1'b1;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      p   = int'($urandom_range(1, 3));
      r   = p + int'($urandom_range(1, 30));
      len = r + 2;
      // Cycle numbering restarts per hold; state is IDLE at c = 0.
      for (int c = 0; c < len; c++) begin
        n = c + 1;
        i_press   = (c == p);
        i_release = (c == r);
        exp_q.push_back({(n >= p + 1 && n <= r),
                         (n == p + 1 || (n >= p + 1 + DLY && n <= r &&
                                         (n - (p + 1 + DLY)) % RATE == 0))});
        @(posedge clk); #1;
        got = exp_q.pop_front();
        checks++;
        if ({o_held, o_fire} !== got) begin
          errors++;
          $display("FAIL back_to_back hold %0d p %0d r %0d cyc %0d got held/fire %b exp %b",
                   k, p, r, n, {o_held, o_fire}, got);
        end
      end
    end
  endtask

  // ---- sequence + report --------------------------------------------------
  initial begin
    i_rst       = 1'b1;
    i_press     = 1'b0;
    i_release   = 1'b0;
    i_repeat_en = 1'b1;
    test_reset();
    test_repeat();
    test_early_release();
    test_no_repeat();
    test_collision();
    test_reset_mid();
    test_release_at_zero();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_button_repeater
